// File: rtl/fp_div_result_queue.sv
// Result FIFO behind the bfloat16 divider: first-word fall-through queue of
// quotient+flags, almost-full credit for the issuer, sticky exception/overrun flags.
module fp_div_result_queue #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [15:0]                in_quotient,
    input  logic                       in_underflow,
    input  logic                       in_overflow,
    input  logic                       in_inexact,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_quotient,
    output logic [2:0]                 out_flags,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [2:0]                 sticky_flags,
    output logic                       overrun,
    input  logic                       flags_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry layout: {underflow, overflow, inexact, quotient[15:0]}
    logic [18:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_almost_full;
    logic [2:0]    r_sticky;
    logic          r_overrun;

    logic [18:0]   w_head;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_next_count;

    assign w_head = r_mem[r_rd_ptr];
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) & out_ready;
    // The divider cannot stall: a full queue only takes a result if it frees a slot this cycle.
    assign w_push = in_valid & (~w_full | w_pop);
    assign w_drop = in_valid & w_full & ~w_pop;

    always_comb begin
        w_next_count = r_count;
        if (w_push && !w_pop) begin
            w_next_count = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_next_count = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_underflow, in_overflow, in_inexact, in_quotient};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count       <= w_next_count;
            r_almost_full <= (w_next_count >= CW'(AF_LEVEL));
        end
    end

    // Flags commit on consumption; a same-cycle pop or drop wins over flags_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky  <= 3'b000;
            r_overrun <= 1'b0;
        end else begin
            if (flags_clr) begin
                r_sticky <= w_pop ? w_head[18:16] : 3'b000;
            end else if (w_pop) begin
                r_sticky <= r_sticky | w_head[18:16];
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (flags_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_quotient = w_head[15:0];
    assign out_flags    = w_head[18:16];
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign sticky_flags = r_sticky;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fp_div_result_queue.sv
// Directed and random checks for the divider result FIFO (DEPTH=4, AF_LEVEL=3).
module tb_fp_div_result_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_quotient;
    logic        in_underflow;
    logic        in_overflow;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_quotient;
    logic [2:0]  out_flags;
    logic        almost_full;
    logic [2:0]  count;
    logic [2:0]  sticky_flags;
    logic        overrun;
    logic        flags_clr;

    int n_checks = 0;
    int n_errors = 0;
    logic [18:0] exp_q[$];

    fp_div_result_queue #(.DEPTH(4), .AF_LEVEL(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_quotient  (in_quotient),
        .in_underflow (in_underflow),
        .in_overflow  (in_overflow),
        .in_inexact   (in_inexact),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_flags    (out_flags),
        .almost_full  (almost_full),
        .count        (count),
        .sticky_flags (sticky_flags),
        .overrun      (overrun),
        .flags_clr    (flags_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input logic [15:0] q, input logic [2:0] f);
        in_valid     = 1'b1;
        in_quotient  = q;
        {in_underflow, in_overflow, in_inexact} = f;
        step();
        in_valid     = 1'b0;
        {in_underflow, in_overflow, in_inexact} = 3'b000;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] q);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_q"}, out_quotient, q);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_count"}, count, 3'd0);
        check({tag, "_af"}, almost_full, 1'b0);
        check({tag, "_sticky"}, sticky_flags, 3'b000);
        check({tag, "_ovr"}, overrun, 1'b0);
    endtask

    initial begin
        logic [15:0] rq;
        logic [2:0]  rf;
        logic        pop;
        logic        push;

        reset = 1'b1; in_valid = 1'b0; in_quotient = '0;
        in_underflow = 1'b0; in_overflow = 1'b0; in_inexact = 1'b0;
        out_ready = 1'b0; flags_clr = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check_idle("rst");

        // single entry, one-cycle latency
        push_val(16'h3F80, 3'b000);
        check("one_valid", out_valid, 1'b1);
        check("one_q", out_quotient, 16'h3F80);
        check("one_count", count, 3'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("one_empty", out_valid, 1'b0);
        check("one_count0", count, 3'd0);

        // fill, almost_full threshold, drain in order
        push_val(16'h4000, 3'b000);
        push_val(16'h3F00, 3'b000);
        check("af_at2", almost_full, 1'b0);
        push_val(16'hBF80, 3'b000);
        check("af_at3", almost_full, 1'b1);
        push_val(16'h0000, 3'b000);
        check("full_count", count, 3'd4);
        check("full_af", almost_full, 1'b1);
        pop_check("d0", 16'h4000);
        pop_check("d1", 16'h3F00);
        pop_check("d2", 16'hBF80);
        pop_check("d3", 16'h0000);
        check("drain_count", count, 3'd0);
        check("drain_af", almost_full, 1'b0);
        push_val(16'h1111, 3'b000);
        push_val(16'h2222, 3'b000);
        pop_check("w0", 16'h1111);
        pop_check("w1", 16'h2222);

        // drop while full, then push with simultaneous pop
        push_val(16'h0A01, 3'b000);
        push_val(16'h0A02, 3'b000);
        push_val(16'h0A03, 3'b000);
        push_val(16'h0A04, 3'b000);
        push_val(16'h7F80, 3'b000);
        check("drop_ovr", overrun, 1'b1);
        check("drop_count", count, 3'd4);
        check("drop_head", out_quotient, 16'h0A01);
        in_valid = 1'b1; in_quotient = 16'h7F80; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp_count", count, 3'd4);
        pop_check("pp0", 16'h0A02);
        pop_check("pp1", 16'h0A03);
        pop_check("pp2", 16'h0A04);
        pop_check("pp3", 16'h7F80);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        check("clr_ovr", overrun, 1'b0);

        // sticky flags commit on pop; pop beats flags_clr
        push_val(16'h0080, 3'b100);
        push_val(16'h3F81, 3'b001);
        check("stk_pre", sticky_flags, 3'b000);
        check("stk_headf", out_flags, 3'b100);
        pop_check("stk0", 16'h0080);
        check("stk_1", sticky_flags, 3'b100);
        check("stk_headf2", out_flags, 3'b001);
        flags_clr = 1'b1;
        pop_check("stk1", 16'h3F81);
        flags_clr = 1'b0;
        check("stk_clr_pop", sticky_flags, 3'b001);

        // drop beats flags_clr
        push_val(16'h0B01, 3'b000);
        push_val(16'h0B02, 3'b000);
        push_val(16'h0B03, 3'b000);
        push_val(16'h0B04, 3'b000);
        flags_clr = 1'b1;
        push_val(16'h0B05, 3'b000);
        flags_clr = 1'b0;
        check("clr_drop_ovr", overrun, 1'b1);
        check("clr_drop_stk", sticky_flags, 3'b000);

        // asynchronous reset mid-cycle with 3 entries queued
        pop_check("ar0", 16'h0B01);
        push_val(16'h0000, 3'b010);
        pop_check("ar1", 16'h0B02);
        check("ar_pre_count", count, 3'd3);
        #2 reset = 1'b1;
        #1;
        check_idle("areset");
        #1 reset = 1'b0;
        push_val(16'h1234, 3'b011);
        check("post_count", count, 3'd1);
        check("post_flags", out_flags, 3'b011);
        pop_check("post0", 16'h1234);
        check("post_stk", sticky_flags, 3'b011);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;

        // random traffic, issuer respects almost_full
        for (int i = 0; i < 10000; i++) begin
            rq   = 16'($urandom_range(0, 16'hFFFF));
            rf   = 3'($urandom_range(0, 7));
            push = !almost_full && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            pop  = out_ready && (exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("rnd_head", {out_flags, out_quotient}, exp_q[0]);
            end
            in_valid = push;
            in_quotient = rq;
            {in_underflow, in_overflow, in_inexact} = rf;
            if (pop) void'(exp_q.pop_front());
            if (push && (exp_q.size() < 4)) exp_q.push_back({rf, rq});
            step();
            check("rnd_count", count, 3'(exp_q.size()));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("rnd_ovr", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
